// File: rtl/noc_node_traffic_gen_if.sv
// Resource channel pair between a NoC node and its traffic generator/sink.
// master = traffic generator side, slave = NoC router side.
interface noc_node_traffic_gen_if #(
  parameter int CHANNEL_W = 10
);
  logic [CHANNEL_W-1:0] tx_data;
  logic                 tx_vld;
  logic                 tx_rdy;
  logic [CHANNEL_W-1:0] rx_data;
  logic                 rx_vld;
  logic                 rx_rdy;

  modport master (
    output tx_data, tx_vld,
    input  tx_rdy,
    input  rx_data, rx_vld,
    output rx_rdy
  );

  modport slave (
    input  tx_data, tx_vld,
    output tx_rdy,
    output rx_data, rx_vld,
    input  rx_rdy
  );
endinterface

// File: rtl/noc_node_traffic_gen.sv
// Per-node NoC traffic generator (HEAD/BODY/TAIL bursts) and sink checker.
// Optional macro NOC_TGEN_RX_BP_EN: LFSR-driven pseudo-random rx backpressure.
module noc_node_traffic_gen #(
  parameter int ROW_N      = 3,
  parameter int COL_M      = 3,
  parameter int NODE_ROW   = 0,
  parameter int NODE_COL   = 0,
  parameter int CHANNEL_W  = 10,
  parameter int FLIT_ID_W  = 2,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 0,
  localparam int ROW_W     = (ROW_N > 1) ? $clog2(ROW_N) : 1,
  localparam int COL_W     = (COL_M > 1) ? $clog2(COL_M) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ROW_W-1:0]      dest_row_i,
  input  logic [COL_W-1:0]      dest_col_i,
  input  logic [LEN_W-1:0]      body_len_i,
  input  logic [7:0]            pckt_num_i,
  output logic                  busy_o,
  output logic                  done_o,
  noc_node_traffic_gen_if.master ch,
  output logic [CNT_W-1:0]      rx_pckt_cnt_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic                  err_o
);

  localparam int PLD_W = CHANNEL_W - FLIT_ID_W;
  localparam int IDX_W = LEN_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_TAIL,
    S_GAP
  } gen_state_e;

  function automatic logic [PLD_W-1:0] idx_pld(input logic [IDX_W-1:0] v);
    logic [PLD_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < IDX_W; i++) begin
      if (i < PLD_W) r[i] = v[i];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- generator
  gen_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [8:0]           pkt_left_q, pkt_left_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [ROW_W-1:0]     drow_q;
  logic [COL_W-1:0]     dcol_q;
  logic [LEN_W-1:0]     blen_q;
  logic                 load;
  logic                 done_d;
  logic                 tx_hs;
  logic [ROW_W-1:0]     drow_n;
  logic [COL_W-1:0]     dcol_n;
  logic [PLD_W-1:0]     head_pld;
  logic [CHANNEL_W-1:0] flit_d;
  logic [CHANNEL_W-1:0] tx_data_q;
  logic                 tx_vld_q;
  logic                 done_q;

  assign tx_hs = tx_vld_q && ch.tx_rdy;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkt_left_d = pkt_left_q;
    gap_d      = gap_q;
    load       = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load       = 1'b1;
          state_d    = S_HEAD;
          pkt_left_d = {pckt_num_i == 8'd0, pckt_num_i};
        end
      end
      S_HEAD: begin
        if (tx_hs) begin
          idx_d   = IDX_W'(1);
          state_d = (blen_q == '0) ? S_TAIL : S_BODY;
        end
      end
      S_BODY: begin
        if (tx_hs) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == {1'b0, blen_q}) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (tx_hs) begin
          pkt_left_d = pkt_left_q - 9'd1;
          if (pkt_left_q == 9'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
          end else begin
            state_d = S_HEAD;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_HEAD;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The flit register is loaded from the next state, so the HEAD of a fresh
  // burst must see the destination inputs directly rather than the captures.
  assign drow_n = load ? dest_row_i : drow_q;
  assign dcol_n = load ? dest_col_i : dcol_q;

  always_comb begin
    head_pld = '0;
    head_pld[ROW_W+COL_W-1:0] = {drow_n, dcol_n};
    flit_d = '0;
    case (state_d)
      S_HEAD:  flit_d = {ID_HEAD, head_pld};
      S_BODY:  flit_d = {ID_BODY, idx_pld(idx_d)};
      S_TAIL:  flit_d = {ID_TAIL, idx_pld(idx_d)};
      default: flit_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pkt_left_q <= '0;
      gap_q      <= '0;
      drow_q     <= '0;
      dcol_q     <= '0;
      blen_q     <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_left_q <= pkt_left_d;
      gap_q      <= gap_d;
      if (load) begin
        drow_q <= dest_row_i;
        dcol_q <= dest_col_i;
        blen_q <= body_len_i;
      end
      tx_data_q  <= flit_d;
      tx_vld_q   <= (state_d == S_HEAD) || (state_d == S_BODY) || (state_d == S_TAIL);
      done_q     <= done_d;
    end
  end

  assign ch.tx_data = tx_data_q;
  assign ch.tx_vld  = tx_vld_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

  // --------------------------------------------------------------------- sink
  logic [FLIT_ID_W-1:0] rx_id;
  logic [PLD_W-1:0]     rx_pld;
  logic                 rx_hs;
  logic                 dest_hit;
  logic                 open_q, open_d;
  logic [PLD_W-1:0]     exp_q, exp_d;
  logic                 pkt_err_q, pkt_err_d;
  logic                 rx_err;
  logic                 rx_close;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [CNT_W-1:0]     err_cnt_q;
  logic                 err_q;

  assign rx_id    = ch.rx_data[CHANNEL_W-1 -: FLIT_ID_W];
  assign rx_pld   = ch.rx_data[PLD_W-1:0];
  assign rx_hs    = ch.rx_vld && ch.rx_rdy;
  assign dest_hit = (rx_pld[ROW_W+COL_W-1:0] == {ROW_W'(NODE_ROW), COL_W'(NODE_COL)});

  always_comb begin
    rx_err    = 1'b0;
    rx_close  = 1'b0;
    open_d    = open_q;
    exp_d     = exp_q;
    pkt_err_d = pkt_err_q;
    if (rx_hs) begin
      case (rx_id)
        ID_HEAD: begin
          rx_err    = open_q || !dest_hit;
          open_d    = 1'b1;
          exp_d     = PLD_W'(1);
          pkt_err_d = !dest_hit;
        end
        ID_BODY, ID_TAIL: begin
          if (!open_q) begin
            rx_err = 1'b1;
          end else begin
            if (rx_pld != exp_q) begin
              rx_err = 1'b1;
              exp_d  = rx_pld + PLD_W'(1);
            end else begin
              exp_d  = exp_q + PLD_W'(1);
            end
            if (rx_id == ID_TAIL) begin
              open_d    = 1'b0;
              pkt_err_d = 1'b0;
              rx_close  = !rx_err && !pkt_err_q;
            end else begin
              pkt_err_d = pkt_err_q || rx_err;
            end
          end
        end
        default: begin
          rx_err    = 1'b1;
          pkt_err_d = pkt_err_q || open_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      open_q    <= 1'b0;
      exp_q     <= '0;
      pkt_err_q <= 1'b0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      open_q    <= open_d;
      exp_q     <= exp_d;
      pkt_err_q <= pkt_err_d;
      if (rx_close && (rx_cnt_q != '1))  rx_cnt_q  <= rx_cnt_q + CNT_W'(1);
      if (rx_err && (err_cnt_q != '1))   err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (rx_err)                        err_q     <= 1'b1;
    end
  end

  assign rx_pckt_cnt_o = rx_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign err_o         = err_q;

`ifdef NOC_TGEN_RX_BP_EN
  logic [7:0] lfsr_q;

  // x^8 + x^6 + x^5 + x^4 Fibonacci; seed keeps rx_rdy high in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign ch.rx_rdy = |lfsr_q[1:0];
`else
  assign ch.rx_rdy = 1'b1;
`endif

endmodule

// File: tb/tb_noc_node_traffic_gen.sv
// Directed bench for noc_node_traffic_gen at node (1,2): loopback bursts,
// tx stall, zero-body packets, busy-start rejection, sink errors, mid-burst reset.
module tb_noc_node_traffic_gen;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    drow, dcol;
  logic [3:0]    blen;
  logic [7:0]    pnum;
  logic          busy, done, err;
  logic [15:0]   rx_cnt, err_cnt;
  logic          loop, tb_rdy, inj_vld;
  logic [CW-1:0] inj_data;

  int n_checks = 0;
  int n_errors = 0;
  int stalls   = 0;
  logic [CW-1:0] flits[$];

  always #5 clk = ~clk;

  noc_node_traffic_gen_if #(.CHANNEL_W(CW)) ch ();

  assign ch.tx_rdy  = tb_rdy && (loop ? ch.rx_rdy : 1'b1);
  assign ch.rx_vld  = loop ? (ch.tx_vld && ch.tx_rdy) : inj_vld;
  assign ch.rx_data = loop ? ch.tx_data : inj_data;

  noc_node_traffic_gen #(
    .NODE_ROW (1),
    .NODE_COL (2),
    .CHANNEL_W(CW)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .dest_row_i   (drow),
    .dest_col_i   (dcol),
    .body_len_i   (blen),
    .pckt_num_i   (pnum),
    .busy_o       (busy),
    .done_o       (done),
    .ch           (ch),
    .rx_pckt_cnt_o(rx_cnt),
    .err_cnt_o    (err_cnt),
    .err_o        (err)
  );

  always @(negedge clk) begin
    if (ch.tx_vld && ch.tx_rdy) flits.push_back(ch.tx_data);
    if (rst_n && !ch.rx_rdy) stalls++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [1:0] r, input logic [1:0] c,
                             input logic [3:0] bl, input logic [7:0] pn);
    drow  = r;
    dcol  = c;
    blen  = bl;
    pnum  = pn;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n0 = cycles already elapsed since the start edge; done expected at exp_cyc.
  task automatic wait_done(input string tag, input int n0, input int exp_cyc);
    int n;
    n = n0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_cycle"}, done ? n : 32'hDEAD, exp_cyc);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic check_flits(input string tag, input logic [CW-1:0] exp[$]);
    check({tag, "_flit_count"}, flits.size(), exp.size());
    for (int i = 0; i < exp.size() && i < flits.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), flits[i], exp[i]);
  endtask

  task automatic inject(input logic [CW-1:0] d);
    inj_data = d;
    inj_vld  = 1'b1;
    tick();
    inj_vld  = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] e[$];
    rst_n    = 1'b0;
    start    = 1'b0;
    drow     = '0;
    dcol     = '0;
    blen     = '0;
    pnum     = '0;
    loop     = 1'b1;
    tb_rdy   = 1'b1;
    inj_vld  = 1'b0;
    inj_data = '0;
    tick();
    tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_vld", ch.tx_vld, 0);
    check("rst_tx_data", ch.tx_data, 0);
    check("rst_rx_rdy", ch.rx_rdy, 1);
    check("rst_rx_cnt", rx_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Loopback: dest (1,2), body_len 2, 3 packets
    flits.delete();
    start_burst(2'd1, 2'd2, 4'd2, 8'd3);
    check("lb_busy", busy, 1);
    check("lb_vld", ch.tx_vld, 1);
    check("lb_head", ch.tx_data, 10'h106);
    wait_done("lb", 1, 13);
    tick();
    e = '{10'h106, 10'h201, 10'h202, 10'h303,
          10'h106, 10'h201, 10'h202, 10'h303,
          10'h106, 10'h201, 10'h202, 10'h303};
    check_flits("lb", e);
    check("lb_rx_cnt", rx_cnt, 3);
    check("lb_err_cnt", err_cnt, 0);

    // tx_rdy low 5 cycles while BODY idx1 is presented
    flits.delete();
    start_burst(2'd1, 2'd2, 4'd2, 8'd1);
    tick();
    tb_rdy = 1'b0;
    repeat (5) tick();
    check("stall_vld", ch.tx_vld, 1);
    check("stall_hold", ch.tx_data, 10'h201);
    tb_rdy = 1'b1;
    wait_done("stall", 7, 10);
    tick();
    e = '{10'h106, 10'h201, 10'h202, 10'h303};
    check_flits("stall", e);
    check("stall_rx_cnt", rx_cnt, 4);
    check("stall_err_cnt", err_cnt, 0);

    // body_len 0: HEAD then TAIL idx1
    flits.delete();
    start_burst(2'd1, 2'd2, 4'd0, 8'd1);
    wait_done("b0", 1, 3);
    tick();
    e = '{10'h106, 10'h301};
    check_flits("b0", e);
    check("b0_rx_cnt", rx_cnt, 5);

    // start while busy is ignored
    flits.delete();
    start_burst(2'd1, 2'd2, 4'd1, 8'd2);
    start_burst(2'd0, 2'd0, 4'd3, 8'd5);
    wait_done("busy_start", 2, 7);
    tick();
    e = '{10'h106, 10'h201, 10'h302, 10'h106, 10'h201, 10'h302};
    check_flits("busy_start", e);
    check("busy_start_rx_cnt", rx_cnt, 7);
    check("busy_start_err_cnt", err_cnt, 0);
    check("busy_start_idle", busy, 0);

    // Sink error injection
    loop = 1'b0;
    tick();
    inject(10'h201);
    check("orphan_body_err_cnt", err_cnt, 1);
    check("orphan_body_err", err, 1);
    inject(10'h100);
    check("bad_dest_err_cnt", err_cnt, 2);
    check("bad_dest_rx_cnt", rx_cnt, 7);
    inject(10'h205);
    inject(10'h306);
    check("mismatch_err_cnt", err_cnt, 3);
    check("tainted_close_rx_cnt", rx_cnt, 7);
    inject(10'h106);
    inject(10'h301);
    check("clean_pkt_rx_cnt", rx_cnt, 8);
    check("clean_pkt_err_cnt", err_cnt, 3);
    inject(10'h000);
    check("id0_err_cnt", err_cnt, 4);
    inject(10'h106);
    inject(10'h106);
    check("head_open_err_cnt", err_cnt, 5);
    check("err_sticky", err, 1);

    // Reset for one cycle in the middle of a BODY run
    loop = 1'b1;
    tick();
    start_burst(2'd1, 2'd2, 4'd3, 8'd2);
    tick();
    tick();
    check("mid_body_vld", ch.tx_vld, 1);
    check("mid_body_data", ch.tx_data, 10'h202);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_vld", ch.tx_vld, 0);
    check("mrst_data", ch.tx_data, 0);
    check("mrst_done", done, 0);
    check("mrst_rx_rdy", ch.rx_rdy, 1);
    check("mrst_rx_cnt", rx_cnt, 0);
    check("mrst_err_cnt", err_cnt, 0);
    check("mrst_err", err, 0);
    flits.delete();
    repeat (4) tick();
    check("mrst_no_tail", flits.size(), 0);

`ifdef NOC_TGEN_RX_BP_EN
    check("bp_stalls_seen", stalls > 0, 1);
`else
    check("rx_rdy_never_low", stalls, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
